inst_cache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache between custom_cpu's instruction request/response

---
 rtl/inst_cache_pkg.sv | 48 ++++
 rtl/inst_cache_dm_if.sv | 36 +++
 rtl/icache_line_array.sv | 53 +++++
 rtl/inst_cache_dm.sv | 151 +++++++++++++++
 tb/tb_inst_cache_dm.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared FSM states and address-field helpers for inst_cache_dm
package inst_cache_pkg;

  // One-hot FSM encoding
  typedef enum logic [4:0] {
    ST_WAIT    = 5'b00001,
    ST_TAG_RD  = 5'b00010,
    ST_MEM_REQ = 5'b00100,
    ST_REFILL  = 5'b01000,
    ST_RESP    = 5'b10000
  } state_e;

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int tag_w(input int num_sets, input int line_words);
    return 32 - idx_w(num_sets) - off_w(line_words);
  endfunction

  // Field extractors return right-justified 32-bit values; callers size-cast to field width.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int num_sets,
                                           input int line_words);
    return a >> (idx_w(num_sets) + off_w(line_words));
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int num_sets,
                                           input int line_words);
    return (a >> off_w(line_words)) & (32'(num_sets) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] a, input int line_words);
    return (a >> 2) & (32'(line_words) - 32'd1);
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] a, input int line_words);
    return a & ~((32'(line_words) << 2) - 32'd1);
  endfunction

endpackage

// File: rtl/inst_cache_dm_if.sv
// rtl/inst_cache_dm_if.sv - CPU fetch channel and memory refill channel of inst_cache_dm
interface inst_cache_dm_if;

  logic        from_cpu_inst_req_valid;
  logic [31:0] from_cpu_inst_req_addr;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready;

  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready;
  logic        from_mem_rd_rsp_valid;
  logic [31:0] from_mem_rd_rsp_data;
  logic        from_mem_rd_rsp_last;
  logic        to_mem_rd_rsp_ready;

  // slave is the cache's own view; master is the CPU plus memory environment around it
  modport slave (
    input  from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
    input  from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
    input  from_mem_rd_rsp_last,
    output to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
    output to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );

  modport master (
    output from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
    output from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
    output from_mem_rd_rsp_last,
    input  to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
    input  to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );

endinterface

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - tag, valid and data storage for the direct-mapped icache
// Combinational read of (idx, word); word writes during refill, tag+valid written on last beat.
module icache_line_array
  import inst_cache_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 24,
  localparam int IDX_W     = idx_w(NUM_SETS),
  localparam int WORD_W    = word_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              line_en,
  input  logic [TAG_W-1:0]  line_tag
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [31:0]         data_mem [NUM_SETS*LINE_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_word}];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are only meaningful under a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (line_en) begin
      tag_mem[wr_idx] <= line_tag;
    end
    if (wr_en) begin
      data_mem[{wr_idx, wr_word}] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_cache_dm.sv
// rtl/inst_cache_dm.sv - direct-mapped read-only instruction cache with burst line refill
// Defining ICACHE_PERF_EN adds the hit_cnt/miss_cnt performance counter outputs.
module inst_cache_dm
  import inst_cache_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ICACHE_PERF_EN
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt,
`endif
  inst_cache_dm_if.slave bus
);

  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int WORD_W = word_w(LINE_WORDS);
  localparam int TAG_W  = tag_w(NUM_SETS, LINE_WORDS);

  state_e            state;
  logic [31:0]       addr_q;
  logic [WORD_W:0]   cnt;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic [TAG_W-1:0]  req_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              beat;
  logic              wr_en;
  logic              line_en;

  assign req_idx  = IDX_W'(addr_idx(addr_q, NUM_SETS, LINE_WORDS));
  assign req_word = WORD_W'(addr_word(addr_q, LINE_WORDS));
  assign req_tag  = TAG_W'(addr_tag(addr_q, NUM_SETS, LINE_WORDS));
  assign hit      = rd_valid && (rd_tag == req_tag);

  // cnt's top bit marks a full line; further beats are acknowledged but not stored.
  assign beat     = (state == ST_REFILL) && bus.from_mem_rd_rsp_valid;
  assign wr_en    = beat && !cnt[WORD_W];
  assign line_en  = beat && bus.from_mem_rd_rsp_last;

  icache_line_array #(
    .NUM_SETS   (NUM_SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_line_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_word  (req_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (req_idx),
    .wr_word  (cnt[WORD_W-1:0]),
    .wr_data  (bus.from_mem_rd_rsp_data),
    .line_en  (line_en),
    .line_tag (req_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= ST_WAIT;
      addr_q                    <= '0;
      cnt                       <= '0;
      bus.to_cpu_inst_req_ready  <= 1'b1;
      bus.to_cpu_cache_rsp_valid <= 1'b0;
      bus.to_cpu_cache_rsp_data  <= '0;
      bus.to_mem_rd_req_valid    <= 1'b0;
      bus.to_mem_rd_req_addr     <= '0;
      bus.to_mem_rd_rsp_ready    <= 1'b0;
    end else begin
      unique case (state)
        ST_WAIT: begin
          if (bus.from_cpu_inst_req_valid) begin
            addr_q                   <= bus.from_cpu_inst_req_addr;
            bus.to_cpu_inst_req_ready <= 1'b0;
            state                    <= ST_TAG_RD;
          end
        end
        ST_TAG_RD: begin
          if (hit) begin
            bus.to_cpu_cache_rsp_data  <= rd_data;
            bus.to_cpu_cache_rsp_valid <= 1'b1;
            state                      <= ST_RESP;
          end else begin
            bus.to_mem_rd_req_valid <= 1'b1;
            bus.to_mem_rd_req_addr  <= line_addr(addr_q, LINE_WORDS);
            state                   <= ST_MEM_REQ;
          end
        end
        ST_MEM_REQ: begin
          if (bus.from_mem_rd_req_ready) begin
            bus.to_mem_rd_req_valid <= 1'b0;
            bus.to_mem_rd_rsp_ready <= 1'b1;
            cnt                     <= '0;
            state                   <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (wr_en) begin
            cnt <= cnt + 1'b1;
            if (cnt[WORD_W-1:0] == req_word) begin
              bus.to_cpu_cache_rsp_data <= bus.from_mem_rd_rsp_data;
            end
          end
          if (line_en) begin
            bus.to_mem_rd_rsp_ready    <= 1'b0;
            bus.to_cpu_cache_rsp_valid <= 1'b1;
            state                      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.from_cpu_cache_rsp_ready) begin
            bus.to_cpu_cache_rsp_valid <= 1'b0;
            bus.to_cpu_inst_req_ready  <= 1'b1;
            state                      <= ST_WAIT;
          end
        end
        default: begin
          state                      <= ST_WAIT;
          bus.to_cpu_inst_req_ready  <= 1'b1;
          bus.to_cpu_cache_rsp_valid <= 1'b0;
          bus.to_mem_rd_req_valid    <= 1'b0;
          bus.to_mem_rd_rsp_ready    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_TAG_RD) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache_dm.sv
// tb/tb_inst_cache_dm.sv - self-checking bench for inst_cache_dm against a behavioural cache model
// Honours ICACHE_PERF_EN to connect and check the performance counters.
module tb_inst_cache_dm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_cache_dm_if bus();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  inst_cache_dm dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ICACHE_PERF_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  // Backing memory: explicit overrides, otherwise a fixed hash of the word address.
  logic [31:0] mem_over [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_over.exists(w)) return mem_over[w];
    return (w * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
  endfunction

  // Reference cache: 8 lines of 32 bytes, direct mapped by (addr/32) mod 8, tag = addr/256.
  bit          mv [8];
  logic [31:0] mt [8];
  int          exp_hits = 0;
  int          exp_misses = 0;

  function automatic bit model_access(input logic [31:0] a);
    int          idx;
    logic [31:0] tag;
    idx = int'((a / 32) % 8);
    tag = a / 256;
    if (mv[idx] && mt[idx] == tag) begin
      exp_hits++;
      return 1'b1;
    end
    mv[idx] = 1'b1;
    mt[idx] = tag;
    exp_misses++;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  // Memory responder: optional request stall, random beat gaps, optional reset on a chosen beat.
  int          m_stall = 0;
  int          m_rst_beat = -1;
  bit          m_rst_fired = 0;
  bit          m_busy = 0;
  int          m_beat = 0;
  logic [31:0] m_base = '0;
  logic [31:0] req_log [$];
  int          req_seen_cyc = -1;
  bit          req_pending = 0;
  bit          req_addr_moved = 0;
  logic [31:0] req_first_addr = '0;

  initial begin
    bus.from_mem_rd_req_ready = 1'b0;
    bus.from_mem_rd_rsp_valid = 1'b0;
    bus.from_mem_rd_rsp_data  = '0;
    bus.from_mem_rd_rsp_last  = 1'b0;
    forever begin
      @(negedge clk);
      bus.from_mem_rd_req_ready = 1'b0;
      bus.from_mem_rd_rsp_valid = 1'b0;
      bus.from_mem_rd_rsp_last  = 1'b0;
      if (rst) begin
        m_busy      = 1'b0;
        req_pending = 1'b0;
      end else if (!m_busy) begin
        if (bus.to_mem_rd_req_valid === 1'b1) begin
          if (!req_pending) begin
            req_pending    = 1'b1;
            req_seen_cyc   = cyc;
            req_first_addr = bus.to_mem_rd_req_addr;
          end else if (bus.to_mem_rd_req_addr !== req_first_addr) begin
            req_addr_moved = 1'b1;
          end
          if (m_stall > 0) begin
            m_stall--;
          end else begin
            bus.from_mem_rd_req_ready = 1'b1;
            m_busy      = 1'b1;
            m_base      = bus.to_mem_rd_req_addr;
            m_beat      = 0;
            req_pending = 1'b0;
            req_log.push_back(m_base);
          end
        end
      end else if ($urandom_range(0, 3) != 0) begin
        bus.from_mem_rd_rsp_valid = 1'b1;
        bus.from_mem_rd_rsp_data  = mem_rd(m_base + 32'(m_beat * 4));
        bus.from_mem_rd_rsp_last  = (m_beat == 7);
        if (m_beat == m_rst_beat) begin
          rst         = 1'b1;
          m_rst_fired = 1'b1;
          m_rst_beat  = -1;
          m_busy      = 1'b0;
        end else if (bus.to_mem_rd_rsp_ready === 1'b1) begin
          if (m_beat == 7) m_busy = 1'b0;
          m_beat++;
        end
      end
    end
  end

  // One CPU fetch; returns data, latency (edges from accept to rsp_valid) and handshake flags.
  task automatic fetch(input logic [31:0] a, input int hold, output logic [31:0] d,
                       output int lat, output int acc, output bit extra, output bit unstable);
    int n;
    d = 'x; lat = -1; acc = -1; extra = 1'b0; unstable = 1'b0;
    @(negedge clk);
    bus.from_cpu_inst_req_valid = 1'b1;
    bus.from_cpu_inst_req_addr  = a;
    n = 0;
    while (bus.to_cpu_inst_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.to_cpu_inst_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_accept addr=%h req_ready=%b required 1", a, bus.to_cpu_inst_req_ready);
      bus.from_cpu_inst_req_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(negedge clk);
    bus.from_cpu_inst_req_valid = 1'b0;
    bus.from_cpu_inst_req_addr  = $urandom();
    n = 0;
    while (bus.to_cpu_cache_rsp_valid !== 1'b1 && n < 400) begin
      if (bus.to_cpu_inst_req_ready !== 1'b0) extra = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.to_cpu_cache_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rsp_timeout addr=%h rsp_valid=%b required 1", a, bus.to_cpu_cache_rsp_valid);
      return;
    end
    lat = cyc - acc;
    d   = bus.to_cpu_cache_rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.to_cpu_cache_rsp_valid !== 1'b1 || bus.to_cpu_cache_rsp_data !== d ||
          bus.to_cpu_inst_req_ready !== 1'b0) unstable = 1'b1;
    end
    bus.from_cpu_cache_rsp_ready = 1'b1;
    @(negedge clk);
    bus.from_cpu_cache_rsp_ready = 1'b0;
    if (bus.to_cpu_cache_rsp_valid !== 1'b0 || bus.to_cpu_inst_req_ready !== 1'b1) unstable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.to_cpu_inst_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got=%b required 1", bus.to_cpu_inst_req_ready);
    end
    checks++;
    if (bus.to_cpu_cache_rsp_valid !== 1'b0 || bus.to_cpu_cache_rsp_data !== 32'h0) begin
      errors++; $display("FAIL reset_rsp got valid=%b data=%h required 0/0",
                         bus.to_cpu_cache_rsp_valid, bus.to_cpu_cache_rsp_data);
    end
    checks++;
    if (bus.to_mem_rd_req_valid !== 1'b0 || bus.to_mem_rd_req_addr !== 32'h0 ||
        bus.to_mem_rd_rsp_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mem got req_valid=%b addr=%h rsp_ready=%b required 0/0/0",
                         bus.to_mem_rd_req_valid, bus.to_mem_rd_req_addr, bus.to_mem_rd_rsp_ready);
    end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int lat, acc, n0; bit ex, un, h;
    for (int i = 0; i < 8; i++) mem_over[32'h100 + 32'(4 * i)] = 32'h1000_0000 + 32'(i);
    n0 = req_log.size();
    h  = model_access(32'h104);
    fetch(32'h0000_0104, 0, d, lat, acc, ex, un);
    checks++;
    if (h || req_log.size() != n0 + 1 || req_log[$] !== 32'h0000_0100) begin
      errors++; $display("FAIL cold_miss_req got n=%0d addr=%h required n=%0d addr=00000100",
                         req_log.size() - n0, req_log[$], 1);
    end
    checks++;
    if (req_seen_cyc - acc != 2) begin
      errors++; $display("FAIL cold_miss_req_latency got=%0d required 2", req_seen_cyc - acc);
    end
    checks++;
    if (d !== 32'h1000_0001) begin
      errors++; $display("FAIL cold_miss_data got=%h required 10000001", d);
    end
  endtask

  task automatic test_hit();
    logic [31:0] d; int lat, acc, n0; bit ex, un, h;
    n0 = req_log.size();
    h  = model_access(32'h11C);
    fetch(32'h0000_011C, 0, d, lat, acc, ex, un);
    checks++;
    if (!h || req_log.size() != n0) begin
      errors++; $display("FAIL hit_no_mem got mem_reqs=%0d required 0", req_log.size() - n0);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL hit_latency got=%0d required 2", lat);
    end
    checks++;
    if (d !== 32'h1000_0007) begin
      errors++; $display("FAIL hit_data got=%h required 10000007", d);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int lat, acc, n0; bit ex, un, h;
    n0 = req_log.size();
    h  = model_access(32'h204);
    fetch(32'h0000_0204, 1, d, lat, acc, ex, un);
    checks++;
    if (h || req_log.size() != n0 + 1 || req_log[$] !== 32'h0000_0200 || d !== mem_rd(32'h204)) begin
      errors++; $display("FAIL conflict_fill got addr=%h data=%h required 00000200/%h",
                         req_log[$], d, mem_rd(32'h204));
    end
    n0 = req_log.size();
    h  = model_access(32'h104);
    fetch(32'h0000_0104, 0, d, lat, acc, ex, un);
    checks++;
    if (h || req_log.size() != n0 + 1 || req_log[$] !== 32'h0000_0100 || d !== 32'h1000_0001) begin
      errors++; $display("FAIL conflict_refetch got addr=%h data=%h required 00000100/10000001",
                         req_log[$], d);
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_counts got hit=%0d miss=%0d required 1/3", hit_cnt, miss_cnt);
    end
  endtask
`endif

  task automatic test_backpressure();
    logic [31:0] d; int lat, acc, n0; bit ex, un, h;
    n0 = req_log.size();
    h  = model_access(32'h344);
    m_stall = 5;
    req_addr_moved = 1'b0;
    fetch(32'h0000_0344, 3, d, lat, acc, ex, un);
    checks++;
    if (h || req_addr_moved || req_log.size() != n0 + 1 || req_log[$] !== 32'h0000_0340) begin
      errors++; $display("FAIL bp_mem_req got moved=%b addr=%h required 0/00000340",
                         req_addr_moved, req_log[$]);
    end
    checks++;
    if (ex || un) begin
      errors++; $display("FAIL bp_cpu_side got extra_accept=%b rsp_unstable=%b required 0/0", ex, un);
    end
    checks++;
    if (d !== mem_rd(32'h344)) begin
      errors++; $display("FAIL bp_data got=%h required %h", d, mem_rd(32'h344));
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d; int lat, acc, n0, n; bit ex, un, h;
    m_rst_fired = 1'b0;
    m_rst_beat  = 3;
    @(negedge clk);
    bus.from_cpu_inst_req_valid = 1'b1;
    bus.from_cpu_inst_req_addr  = 32'h0000_0404;
    n = 0;
    while (bus.to_cpu_inst_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.from_cpu_inst_req_valid = 1'b0;
    n = 0;
    while (!m_rst_fired && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!m_rst_fired) begin
      errors++; $display("FAIL rst_refill_trigger got fired=0 required 1");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rst_beat = -1;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.to_cpu_inst_req_ready !== 1'b1 || bus.to_cpu_cache_rsp_valid !== 1'b0 ||
        bus.to_mem_rd_req_valid !== 1'b0 || bus.to_mem_rd_rsp_ready !== 1'b0) begin
      errors++; $display("FAIL rst_refill_idle got ready=%b rsp_v=%b mreq=%b mrdy=%b required 1/0/0/0",
                         bus.to_cpu_inst_req_ready, bus.to_cpu_cache_rsp_valid,
                         bus.to_mem_rd_req_valid, bus.to_mem_rd_rsp_ready);
    end
    n0 = req_log.size();
    h  = model_access(32'h404);
    fetch(32'h0000_0404, 0, d, lat, acc, ex, un);
    checks++;
    if (h || req_log.size() != n0 + 1 || req_log[$] !== 32'h0000_0400 || d !== mem_rd(32'h404)) begin
      errors++; $display("FAIL rst_refill_refetch got n=%0d addr=%h data=%h required 1/00000400/%h",
                         req_log.size() - n0, req_log[$], d, mem_rd(32'h404));
    end
    n0 = req_log.size();
    h  = model_access(32'h41C);
    fetch(32'h0000_041C, 0, d, lat, acc, ex, un);
    checks++;
    if (!h || req_log.size() != n0 || lat != 2 || d !== mem_rd(32'h41C)) begin
      errors++; $display("FAIL rst_refill_full_line got reqs=%0d lat=%0d data=%h required 0/2/%h",
                         req_log.size() - n0, lat, d, mem_rd(32'h41C));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; int lat, acc, n0; bit ex, un, h;
    n0 = req_log.size();
    h  = model_access(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 0, d, lat, acc, ex, un);
    checks++;
    if (h || req_log.size() != n0 + 1 || req_log[$] !== 32'hFFFF_FFE0 || d !== mem_rd(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_fetch got addr=%h data=%h required ffffffe0/%h",
                         req_log[$], d, mem_rd(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d; int lat, acc, n0; bit ex, un, h;
    for (int it = 0; it < 60; it++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      m_stall = $urandom_range(0, 3);
      n0 = req_log.size();
      h  = model_access(a);
      fetch(a, $urandom_range(0, 2), d, lat, acc, ex, un);
      checks++;
      if (d !== mem_rd(a)) begin
        errors++; $display("FAIL rand_data addr=%h got=%h required %h", a, d, mem_rd(a));
      end
      checks++;
      if (h) begin
        if (req_log.size() != n0 || lat != 2) begin
          errors++; $display("FAIL rand_hit addr=%h got reqs=%0d lat=%0d required 0/2",
                             a, req_log.size() - n0, lat);
        end
      end else if (req_log.size() != n0 + 1 || req_log[$] !== (a & 32'hFFFF_FFE0)) begin
        errors++; $display("FAIL rand_miss addr=%h got reqs=%0d line=%h required 1/%h",
                           a, req_log.size() - n0, req_log[$], a & 32'hFFFF_FFE0);
      end
      checks++;
      if (ex || un) begin
        errors++; $display("FAIL rand_handshake addr=%h got extra=%b unstable=%b required 0/0", a, ex, un);
      end
    end
    m_stall = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

  initial begin
    bus.from_cpu_inst_req_valid  = 1'b0;
    bus.from_cpu_inst_req_addr   = '0;
    bus.from_cpu_cache_rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    test_backpressure();
    test_reset_mid_refill();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
